// File: rtl/weight_pkg.sv
// weight_pkg: shared types and defaults for the
// cabin weight-sensing link (encoder and receiver).
package weight_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    PULSE_HI,
    PULSE_LO,
    GAP
  } weight_state_t;

  localparam int WEIGHT_LOAD_W     = 8;
  localparam int WEIGHT_LIMIT      = 8;
  localparam int WEIGHT_MAX_PULSES = 15;
  localparam int WEIGHT_RST_CYCLES = 4;
  localparam int WEIGHT_HALF       = 5;
  localparam int WEIGHT_GAP_CYCLES = 10;

  // bits needed to hold 0..n-1, never less than 1
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/weight_phase_timer.sv
// weight_phase_timer: loadable down-counter that
// times every phase of the weight pulse frame.
module weight_phase_timer
  import weight_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  // load on phase entry, otherwise count down to 0 and hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load_en) begin
      count <= load_val;
    end else if (!zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/weight_pulse_encoder.sv
// weight_pulse_encoder: serializes a load value as a
// framed pulse train on weight_flip.
module weight_pulse_encoder
  import weight_pkg::*;
#(
  parameter int LOAD_W     = WEIGHT_LOAD_W,
  parameter int MAX_PULSES = WEIGHT_MAX_PULSES,
  parameter int LIMIT      = WEIGHT_LIMIT,
  parameter int RST_CYCLES = WEIGHT_RST_CYCLES,
  parameter int HALF       = WEIGHT_HALF,
  parameter int GAP_CYCLES = WEIGHT_GAP_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LOAD_W-1:0] load,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              weight_flip,
  output logic              weight_flip_reset,
  output logic              over_limit,
  output logic              frame_done
);

  localparam int PH_MAX =
    max3(RST_CYCLES, HALF, GAP_CYCLES);
  localparam int TW = cnt_width(PH_MAX);
  localparam int CW = cnt_width(MAX_PULSES + 1);

  localparam logic [TW-1:0] RST_LD =
    TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] HALF_LD =
    TW'(HALF - 1);
  localparam logic [TW-1:0] GAP_LD =
    TW'(GAP_CYCLES - 1);

  localparam logic [LOAD_W-1:0] MAXP_L =
    LOAD_W'(MAX_PULSES);
  localparam logic [LOAD_W-1:0] LIMIT_L =
    LOAD_W'(LIMIT);
  localparam logic [CW-1:0] MAXP_C =
    CW'(MAX_PULSES);
  localparam logic [CW-1:0] ONE_C =
    CW'(1);

  weight_state_t state;
  weight_state_t nxt;

  logic [CW-1:0] rem;
  logic [CW-1:0] rem_d;
  logic [CW-1:0] n_sat;
  logic          ovl_d;

  logic          ld_en;
  logic [TW-1:0] ld_val;
  logic [TW-1:0] cnt;
  logic [TW-1:0] cnt_nxt;
  logic          zero;

  logic flip_d;
  logic clr_d;
  logic rdy_d;
  logic done_d;

  weight_phase_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (ld_en),
    .load_val(ld_val),
    .count   (cnt),
    .zero    (zero)
  );

  assign n_sat = (load > MAXP_L)
               ? MAXP_C
               : CW'(load);

  // next state, phase timer loads, registered output values
  always_comb begin
    nxt    = state;
    ld_en  = 1'b0;
    ld_val = '0;
    rem_d  = rem;
    ovl_d  = over_limit;
    unique case (state)
      IDLE: begin
        if (load_valid && load_ready) begin
          nxt    = CLEAR;
          ld_en  = 1'b1;
          ld_val = RST_LD;
          rem_d  = n_sat;
          ovl_d  = (load >= LIMIT_L);
        end
      end
      CLEAR: begin
        if (zero) begin
          ld_en = 1'b1;
          if (rem != '0) begin
            nxt    = PULSE_HI;
            ld_val = HALF_LD;
          end else begin
            nxt    = GAP;
            ld_val = GAP_LD;
          end
        end
      end
      PULSE_HI: begin
        if (zero) begin
          nxt    = PULSE_LO;
          ld_en  = 1'b1;
          ld_val = HALF_LD;
        end
      end
      PULSE_LO: begin
        if (zero) begin
          ld_en = 1'b1;
          rem_d = rem - 1'b1;
          if (rem != ONE_C) begin
            nxt    = PULSE_HI;
            ld_val = HALF_LD;
          end else begin
            nxt    = GAP;
            ld_val = GAP_LD;
          end
        end
      end
      GAP: begin
        if (zero) begin
          nxt = IDLE;
        end
      end
      default: begin
        nxt = IDLE;
      end
    endcase

    if (ld_en) begin
      cnt_nxt = ld_val;
    end else if (zero) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt - 1'b1;
    end

    flip_d = (nxt == PULSE_HI);
    clr_d  = (nxt == CLEAR);
    rdy_d  = (nxt == IDLE);
    done_d = (nxt == GAP) && (cnt_nxt == '0);
  end

  // state, pulse count and registered link outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      rem               <= '0;
      over_limit        <= 1'b0;
      weight_flip       <= 1'b0;
      weight_flip_reset <= 1'b1;
      load_ready        <= 1'b0;
      frame_done        <= 1'b0;
    end else begin
      state             <= nxt;
      rem               <= rem_d;
      over_limit        <= ovl_d;
      weight_flip       <= flip_d;
      weight_flip_reset <= clr_d;
      load_ready        <= rdy_d;
      frame_done        <= done_d;
    end
  end

endmodule

// File: tb/tb_weight_pulse_encoder.sv
// tb_weight_pulse_encoder: table vectors + scoreboard
// for the weight pulse frame encoder.
module tb_weight_pulse_encoder;

  localparam int RST  = 4;
  localparam int HALF = 5;

  logic       clk;
  logic       rst_n;
  logic [7:0] load;
  logic       load_valid;
  logic       load_ready;
  logic       weight_flip;
  logic       weight_flip_reset;
  logic       over_limit;
  logic       frame_done;

  weight_pulse_encoder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .load             (load),
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .weight_flip      (weight_flip),
    .weight_flip_reset(weight_flip_reset),
    .over_limit       (over_limit),
    .frame_done       (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ld;
    int         pulses;
    int         over;
    int         len;
  } vec_t;

  typedef struct {
    int pulses;
    int over;
    int len;
    int acc;
  } exp_t;

  vec_t vecs[8];
  exp_t q[$];

  int n_chk;
  int n_pass;
  int cyc;
  int rst_seen;
  int tot_edges;

  int k;
  int prev_flip;
  int chk_rdy;
  int clr_n, clr_first, clr_last;
  int edges, first_edge, last_edge;
  int space_err, rdy_err, ovl_err;

  task automatic chk(
    input string nm,
    input int    act,
    input int    exp
  );
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d",
                  nm, act, exp);
  endtask

  task automatic clr_acc();
    clr_n = 0; clr_first = 0; clr_last = 0;
    edges = 0; first_edge = 0; last_edge = 0;
    space_err = 0; rdy_err = 0; ovl_err = 0;
  endtask

  // cycle counter and registered view of reset
  initial begin
    cyc = 0;
    rst_seen = 0;
    forever begin
      @(posedge clk);
      cyc++;
      rst_seen = rst_n;
    end
  end

  // frame monitor: checks each frame against queue head
  initial begin
    prev_flip = 0;
    chk_rdy = 0;
    tot_edges = 0;
    clr_acc();
    forever begin
      @(negedge clk);
      if (rst_seen == 0) begin
        prev_flip = 0;
        chk_rdy = 0;
        clr_acc();
      end else begin
        if (chk_rdy != 0) begin
          chk("ready_after_done", load_ready, 1);
          chk_rdy = 0;
        end
        if (weight_flip && prev_flip == 0)
          tot_edges++;
        if (q.size() > 0) begin
          k = cyc - q[0].acc + 1;
          if (weight_flip_reset) begin
            clr_n++;
            clr_last = k;
            if (clr_first == 0) clr_first = k;
          end
          if (weight_flip && prev_flip == 0) begin
            edges++;
            if (first_edge == 0) first_edge = k;
            else if (k - last_edge != 2 * HALF)
              space_err++;
            last_edge = k;
          end
          if (load_ready) rdy_err++;
          if (weight_flip && weight_flip_reset)
            ovl_err++;
          if (frame_done) begin
            chk("pulses", edges, q[0].pulses);
            chk("frame_len", k, q[0].len);
            chk("over_limit", over_limit, q[0].over);
            chk("clr_cycles", clr_n, RST);
            chk("clr_first", clr_first, 1);
            chk("clr_last", clr_last, RST);
            chk("first_edge", first_edge,
                (q[0].pulses > 0) ? RST + 1 : 0);
            chk("edge_spacing", space_err, 0);
            chk("ready_low", rdy_err, 0);
            chk("flip_rst_excl", ovl_err, 0);
            void'(q.pop_front());
            clr_acc();
            chk_rdy = 1;
          end
        end else if (frame_done) begin
          chk("done_expected", q.size(), 1);
        end
        prev_flip = weight_flip ? 1 : 0;
      end
    end
  end

  task automatic send(
    input logic [7:0] v,
    input int         push,
    input int         p,
    input int         o,
    input int         len
  );
    int t;
    exp_t e;
    t = 0;
    while (!load_ready && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready_wait", load_ready, 1);
    load = v;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    if (push != 0) begin
      e.pulses = p;
      e.over   = o;
      e.len    = len;
      e.acc    = cyc;
      q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (q.size() != 0 && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    int t;
    int e0;

    vecs[0] = '{8'd3,   3,  0, 44};
    vecs[1] = '{8'd0,   0,  0, 14};
    vecs[2] = '{8'd200, 15, 1, 164};
    vecs[3] = '{8'd8,   8,  1, 94};
    vecs[4] = '{8'd7,   7,  0, 84};
    vecs[5] = '{8'd15,  15, 1, 164};
    vecs[6] = '{8'd16,  15, 1, 164};
    vecs[7] = '{8'd1,   1,  0, 24};

    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    load = '0;
    load_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_flip", weight_flip, 0);
    chk("rst_clear", weight_flip_reset, 1);
    chk("rst_ready", load_ready, 0);
    chk("rst_over", over_limit, 0);
    chk("rst_done", frame_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", load_ready, 1);
    chk("rel_clear", weight_flip_reset, 0);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].ld, 1, vecs[i].pulses,
           vecs[i].over, vecs[i].len);
      wait_drain(400);
      chk("over_hold", over_limit, vecs[i].over);
    end

    // load offered mid-frame must be dropped
    send(8'd2, 1, 2, 0, 34);
    t = 0;
    while (!weight_flip && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("pulse_seen", weight_flip, 1);
    chk("busy_ready", load_ready, 0);
    load = 8'd12;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    wait_drain(200);
    e0 = tot_edges;
    repeat (30) @(posedge clk);
    #1;
    chk("no_extra_frame", tot_edges, e0);
    chk("idle_ready", load_ready, 1);

    // reset in the second high phase of a load=5 frame
    e0 = tot_edges;
    send(8'd5, 0, 0, 0, 0);
    t = 0;
    while (tot_edges < e0 + 2 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("second_pulse", tot_edges - e0, 2);
    chk("in_pulse_hi", weight_flip, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_flip", weight_flip, 0);
    chk("mid_rst_clear", weight_flip_reset, 1);
    chk("mid_rst_ready", load_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_ready", load_ready, 1);
    chk("mid_rel_clear", weight_flip_reset, 0);
    e0 = tot_edges;
    repeat (80) @(posedge clk);
    #1;
    chk("no_resume", tot_edges, e0);
    chk("still_idle", load_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
